wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline write-back stage and a long-latency unit (MUL/DIV, late loads).
- Sits between the write-back result mux plus the long-latency unit on one side and the register file on the other.
- Long-latency results are buffered in a small FIFO and drained into idle write-port cycles.
- Exports a pending-destination mask for the hazard unit and, optionally, a starvation guard that briefly stalls the pipeline.

Parameters:
- DEPTH, 2, long-latency result FIFO entries; power of 2, >= 2.
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may be denied before forced grant (guard build only); >= 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline write-back valid.
- pipe_rd  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline write-back data (write-back mux output).
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept; transfer on lu_valid && lu_ready at rising edge.
- lu_rd  in  5  long-latency destination register.
- lu_wdata  in  32  long-latency result.
- pipe_stall  out  1  pipeline must hold its write-back stage this cycle.
- pend_mask  out  32  bit n set while any FIFO entry targets xn; bit 0 always 0.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  5  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).

Behaviour:
- Reset (rst high at edge): FIFO emptied, starve counter = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0. pend_mask = 0 and pipe_stall = 0 follow from the empty FIFO. lu_ready = 0 while rst is high.
- Reset mid-operation: all buffered results are discarded. No rf_we pulse occurs on the edge after rst.
- lu_ready = !full && !rst. It depends only on FIFO state and is never derived from the same-cycle pop (no full-FIFO pass-through).
- Accepted lu results with lu_rd == 0 are consumed but not pushed.
- Port demand:
  - pipe_req = pipe_we && pipe_rd != 0.
  - pipe_we with pipe_rd == 0 leaves the port idle.
- Grant priority per cycle, combinational:
  - 1. force (guard build only): grant FIFO head, pop.
  - 2. pipe_req: grant pipeline.
  - 3. FIFO not empty: grant FIFO head, pop.
  - 4. none.
- Output stage:
  - On each edge, rf_we <= (grant != none).
  - When rf_we is set, rf_waddr/rf_wdata load the granted source.
  - When rf_we is clear, rf_waddr/rf_wdata hold their previous values.
  - Latency: pipeline input -> rf_we is 1 cycle.
  - Latency: lu accept -> rf_we is >= 2 cycles; no bypass of an empty FIFO.
- Push and pop in the same cycle are legal (full excluded by lu_ready). Occupancy is unchanged. Order is strictly FIFO.
- pend_mask is the OR of one-hot(rd) over valid FIFO entries, decoded from stored state. It updates after the edge that pushes or pops.
- pend_mask is advisory: the hazard unit must stall any pipeline write to a pending rd. The arbiter itself does not reorder or block such writes.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

Optional Feature:
- Macro: WB_ARB_STARVE_GUARD_EN.
- Defined:
  - Starve counter increments each cycle the FIFO is non-empty and the head is not granted.
  - Counter clears on a head pop or when the FIFO is empty.
  - When the counter == STARVE_LIMIT, force = 1 and pipe_stall = 1 combinationally that cycle. The head is written, and the counter clears at the edge.
  - The pipeline holds pipe_we/pipe_rd/pipe_wdata and retries next cycle.
- Undefined: no counter; pipe_stall tied to 0; strict pipeline priority. The FIFO may stay full indefinitely, backpressuring the unit via lu_ready.

Test Plan:
- Reset -> rf_we=0, rf_waddr=0, rf_wdata=0, pend_mask=0, lu_ready=0 while rst=1, lu_ready=1 the cycle after rst falls.
- pipe_we=1, pipe_rd=5, pipe_wdata=AAAA_BBBB for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=AAAA_BBBB; pipe_rd=0 variant -> rf_we stays 0.
- lu push rd=7 data=1234_5678 with pipe idle -> pend_mask=0000_0080 one cycle after accept; rf_we=1, rf_waddr=7 two cycles after accept; pend_mask back to 0 after the pop.
- Pipe busy every cycle and two lu pushes (rd=3, rd=4) with DEPTH=2 -> lu_ready=0 after 2nd accept. Guard off: no lu write until pipe_we drops, then rd=3 then rd=4 on consecutive cycles.
- Guard on, STARVE_LIMIT=4, pipe busy, one lu entry rd=9 -> pipe_stall=1 exactly on 5th cycle of denial; rf_waddr=9 next cycle; stalled pipeline write lands the cycle after.
- FIFO holding rd=3,4, rst asserted one cycle -> no rf_we after reset, pend_mask=0, subsequent lu push rd=6 written normally.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back vs. buffered long-latency results.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wdata,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_wdata,
    output logic        pipe_stall,
    output logic [31:0] pend_mask,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [4:0]  r_rd   [DEPTH];
    logic [31:0] r_data [DEPTH];
    logic [AW:0] r_wptr, r_rptr;

    logic [AW:0]   w_count;
    logic [AW-1:0] w_offs;
    logic [31:0]   w_mask;
    logic          w_empty, w_full, w_push, w_pipe_req;
    logic          w_force, w_gnt_fifo, w_gnt_pipe;

    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign lu_ready   = !w_full && !rst;
    // x0 results are handshaken but never occupy a slot.
    assign w_push     = lu_valid && lu_ready && (lu_rd != 5'd0);
    assign w_pipe_req = pipe_we && (pipe_rd != 5'd0);

    assign w_gnt_fifo = w_force || (!w_pipe_req && !w_empty);
    assign w_gnt_pipe = w_pipe_req && !w_force;

`ifdef WB_ARB_STARVE_GUARD_EN
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve;

    assign w_force    = !w_empty && (r_starve == CW'(STARVE_LIMIT));
    assign pipe_stall = w_force;

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_gnt_fifo)
            r_starve <= '0;
        else
            r_starve <= r_starve + 1'b1;
    end
`else
    assign w_force    = 1'b0;
    assign pipe_stall = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_rd[r_wptr[AW-1:0]]   <= lu_rd;
                r_data[r_wptr[AW-1:0]] <= lu_wdata;
                r_wptr                 <= r_wptr + 1'b1;
            end
            if (w_gnt_fifo)
                r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_we <= w_gnt_fifo || w_gnt_pipe;
            if (w_gnt_fifo) begin
                rf_waddr <= r_rd[r_rptr[AW-1:0]];
                rf_wdata <= r_data[r_rptr[AW-1:0]];
            end else if (w_gnt_pipe) begin
                rf_waddr <= pipe_rd;
                rf_wdata <= pipe_wdata;
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_mask = '0;
        w_offs = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_offs = AW'(i) - r_rptr[AW-1:0];
            if ({1'b0, w_offs} < w_count)
                w_mask[r_rd[i]] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    assign pend_mask = w_mask;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wdata;
    logic        pipe_stall;
    logic [31:0] pend_mask;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wdata(pipe_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_wdata(lu_wdata),
        .pipe_stall(pipe_stall), .pend_mask(pend_mask),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
        lu_valid = 1'b0; lu_rd = '0; lu_wdata = '0;
        tick(); tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", rf_we); end
        n_vec++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
        n_vec++; if (pend_mask !== 32'd0) begin n_err++; $display("FAIL reset_pend: got %h want 0", pend_mask); end
        n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_in_rst: got %b want 0", lu_ready); end
        n_vec++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", pipe_stall); end
        rst = 1'b0;
        tick();
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready_after: got %b want 1", lu_ready); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we_after: got %b want 0", rf_we); end
    endtask

    task automatic test_pipe_write;
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'hAAAA_BBBB;
        tick();
        pipe_we = 1'b0;
        n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL pipe_we: got %b want 1", rf_we); end
        n_vec++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL pipe_waddr: got %0d want 5", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'hAAAA_BBBB) begin n_err++; $display("FAIL pipe_wdata: got %h want aaaabbbb", rf_wdata); end
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wdata = 32'hDEAD_BEEF;
        tick();
        pipe_we = 1'b0;
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL pipe_x0_we: got %b want 0", rf_we); end
        n_vec++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL pipe_x0_hold_addr: got %0d want 5", rf_waddr); end
        n_vec++; if (rf_wdata !== 32'hAAAA_BBBB) begin n_err++; $display("FAIL pipe_x0_hold_data: got %h want aaaabbbb", rf_wdata); end
    endtask

    task automatic test_back_to_back;
        logic [4:0] rds [3];
        rds[0] = 5'd1; rds[1] = 5'd2; rds[2] = 5'd31;
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1; pipe_rd = rds[i]; pipe_wdata = 32'h1000_0000 + 32'(i);
            tick();
            n_vec++; if (rf_we !== 1'b1 || rf_waddr !== rds[i] || rf_wdata !== 32'h1000_0000 + 32'(i)) begin
                n_err++; $display("FAIL b2b_%0d: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                                  i, rf_we, rf_waddr, rf_wdata, rds[i], 32'h1000_0000 + 32'(i));
            end
        end
        pipe_we = 1'b0;
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", rf_we); end
    endtask

    task automatic test_lu_single;
        lu_valid = 1'b1; lu_rd = 5'd7; lu_wdata = 32'h1234_5678;
        tick();
        lu_valid = 1'b0;
        n_vec++; if (pend_mask !== 32'h0000_0080) begin n_err++; $display("FAIL lu_pend: got %h want 00000080", pend_mask); end
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL lu_no_bypass: got %b want 0", rf_we); end
        tick();
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h1234_5678) begin
            n_err++; $display("FAIL lu_write: got we=%b addr=%0d data=%h want we=1 addr=7 data=12345678", rf_we, rf_waddr, rf_wdata);
        end
        n_vec++; if (pend_mask !== 32'd0) begin n_err++; $display("FAIL lu_pend_clear: got %h want 0", pend_mask); end
        lu_valid = 1'b1; lu_rd = 5'd0; lu_wdata = 32'hFFFF_FFFF;
        #1;
        n_vec++; if (lu_ready !== 1'b1) begin n_err++; $display("FAIL lu_x0_ready: got %b want 1", lu_ready); end
        tick();
        lu_valid = 1'b0;
        n_vec++; if (pend_mask !== 32'd0) begin n_err++; $display("FAIL lu_x0_pend: got %h want 0", pend_mask); end
        tick();
        n_vec++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL lu_x0_we: got %b want 0", rf_we); end
    endtask

`ifndef WB_ARB_STARVE_GUARD_EN
    task automatic test_backpressure;
        pipe_we = 1'b1; pipe_rd = 5'd10; pipe_wdata = 32'hA0;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_wdata = 32'h33;
        tick();
        lu_rd = 5'd4; lu_wdata = 32'h44;
        tick();
        lu_rd = 5'd5; lu_wdata = 32'h55;
        n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", lu_ready); end
        n_vec++; if (pend_mask !== 32'h0000_0018) begin n_err++; $display("FAIL bp_pend: got %h want 00000018", pend_mask); end
        tick();
        lu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            pipe_wdata = 32'hB0 + 32'(k);
            n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || pipe_stall !== 1'b0 || pend_mask !== 32'h18) begin
                n_err++; $display("FAIL bp_pipe_pri_%0d: got we=%b addr=%0d stall=%b pend=%h want we=1 addr=10 stall=0 pend=18",
                                  k, rf_we, rf_waddr, pipe_stall, pend_mask);
            end
            tick();
        end
        pipe_we = 1'b0;
        tick();
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin
            n_err++; $display("FAIL bp_drain0: got we=%b addr=%0d data=%h want we=1 addr=3 data=33", rf_we, rf_waddr, rf_wdata);
        end
        n_vec++; if (pend_mask !== 32'h10 || lu_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_drain0_state: got pend=%h ready=%b want pend=10 ready=1", pend_mask, lu_ready);
        end
        tick();
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin
            n_err++; $display("FAIL bp_drain1: got we=%b addr=%0d data=%h want we=1 addr=4 data=44", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        n_vec++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
            n_err++; $display("FAIL bp_done: got we=%b pend=%h want we=0 pend=0", rf_we, pend_mask);
        end
    endtask
`else
    task automatic test_starve_guard;
        pipe_we = 1'b1; pipe_rd = 5'd10; pipe_wdata = 32'hA0;
        lu_valid = 1'b1; lu_rd = 5'd9; lu_wdata = 32'h99;
        tick();
        lu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            pipe_wdata = 32'hA0 + 32'(k);
            #1;
            n_vec++; if (pipe_stall !== 1'b0) begin n_err++; $display("FAIL guard_nostall_%0d: got %b want 0", k, pipe_stall); end
            tick();
            n_vec++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'hA0 + 32'(k)) begin
                n_err++; $display("FAIL guard_pipe_%0d: got addr=%0d data=%h want addr=10 data=%h", k, rf_waddr, rf_wdata, 32'hA0 + 32'(k));
            end
        end
        pipe_rd = 5'd11; pipe_wdata = 32'h55;
        #1;
        n_vec++; if (pipe_stall !== 1'b1) begin n_err++; $display("FAIL guard_stall: got %b want 1", pipe_stall); end
        tick();
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
            n_err++; $display("FAIL guard_force: got we=%b addr=%0d data=%h want we=1 addr=9 data=99", rf_we, rf_waddr, rf_wdata);
        end
        n_vec++; if (pipe_stall !== 1'b0 || pend_mask !== 32'd0) begin
            n_err++; $display("FAIL guard_after: got stall=%b pend=%h want stall=0 pend=0", pipe_stall, pend_mask);
        end
        tick();
        pipe_we = 1'b0;
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11 || rf_wdata !== 32'h55) begin
            n_err++; $display("FAIL guard_retry: got we=%b addr=%0d data=%h want we=1 addr=11 data=55", rf_we, rf_waddr, rf_wdata);
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid;
        pipe_we = 1'b1; pipe_rd = 5'd10; pipe_wdata = 32'hC0;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_wdata = 32'h33;
        tick();
        lu_rd = 5'd4; lu_wdata = 32'h44;
        tick();
        lu_valid = 1'b0; pipe_we = 1'b0;
        n_vec++; if (pend_mask !== 32'h18) begin n_err++; $display("FAIL mid_pend_pre: got %h want 00000018", pend_mask); end
        rst = 1'b1;
        #1;
        n_vec++; if (lu_ready !== 1'b0) begin n_err++; $display("FAIL mid_ready_rst: got %b want 0", lu_ready); end
        tick();
        rst = 1'b0;
        n_vec++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
            n_err++; $display("FAIL mid_rst: got we=%b pend=%h want we=0 pend=0", rf_we, pend_mask);
        end
        tick();
        n_vec++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
            n_err++; $display("FAIL mid_post: got we=%b pend=%h want we=0 pend=0", rf_we, pend_mask);
        end
        lu_valid = 1'b1; lu_rd = 5'd6; lu_wdata = 32'h66;
        tick();
        lu_valid = 1'b0;
        n_vec++; if (pend_mask !== 32'h40) begin n_err++; $display("FAIL mid_push_pend: got %h want 00000040", pend_mask); end
        tick();
        n_vec++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin
            n_err++; $display("FAIL mid_push_write: got we=%b addr=%0d data=%h want we=1 addr=6 data=66", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_back_to_back();
        test_lu_single();
`ifndef WB_ARB_STARVE_GUARD_EN
        test_backpressure();
`else
        test_starve_guard();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
